seg7_message_decoder: RTL and testbench

Receive-side counterpart of the team's 7-segment message scroller. Samples a live 7-segment pattern bus (GFEDCBA, active-high, common cathode) and waits for each pattern to hold steady. It frames letters on blank separators and decodes them to 4-bit character codes. It also tracks the scroller message "HELLO ASIC" and pulses when the full message has been received in order. Used as a loopback checker on the demo PCB and as a bench monitor for the scroller.

---
 rtl/seg7_message_decoder_if.sv | 20 ++
 rtl/seg7_message_decoder.sv | 155 +++++++++++++++
 tb/tb_seg7_message_decoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_message_decoder_if.sv
// Bus between a 7-segment pattern source and the message decoder.
// The master side drives seg_in and observes the decoded results.
interface seg7_message_decoder_if;
  logic [6:0] seg_in;
  logic [3:0] char_code;
  logic       char_valid;
  logic       frame_err;
  logic       msg_match;
  logic [3:0] match_idx;

  modport master (
    output seg_in,
    input  char_code, char_valid, frame_err, msg_match, match_idx
  );

  modport slave (
    input  seg_in,
    output char_code, char_valid, frame_err, msg_match, match_idx
  );
endinterface

// File: rtl/seg7_message_decoder.sv
// Decodes settled 7-segment patterns into character codes, frames them on
// blank separators and tracks the "HELLO ASIC" message sequence.
module seg7_message_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  reset,
  seg7_message_decoder_if.slave bus
);

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);
  localparam logic [15:0] SETTLE_AT  = 16'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GAP, HOLD} state_t;

  function automatic logic [3:0] decode(input logic [6:0] pat);
    case (pat)
      7'h00:   decode = 4'h0;
      7'h76:   decode = 4'h1;
      7'h79:   decode = 4'h2;
      7'h38:   decode = 4'h3;
      7'h3F:   decode = 4'h4;
      7'h77:   decode = 4'h5;
      7'h6D:   decode = 4'h6;
      7'h30:   decode = 4'h7;
      7'h39:   decode = 4'h8;
      default: decode = 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] expected(input logic [3:0] idx);
    case (idx)
      4'd0:    expected = 4'h1;
      4'd1:    expected = 4'h2;
      4'd2:    expected = 4'h3;
      4'd3:    expected = 4'h3;
      4'd4:    expected = 4'h4;
      4'd5:    expected = 4'h5;
      4'd6:    expected = 4'h6;
      4'd7:    expected = 4'h7;
      4'd8:    expected = 4'h8;
      default: expected = 4'hE;
    endcase
  endfunction

  logic [6:0]  seg_p0;
  logic [6:0]  cand_p1;
  logic [15:0] cnt_p1;
  logic        settle;

  // Stage p0/p1: sample, compare against previous sample, count stability.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p0  <= 7'h00;
      cand_p1 <= 7'h00;
      cnt_p1  <= 16'd0;
    end else begin
      seg_p0  <= bus.seg_in;
      cand_p1 <= seg_p0;
      if (seg_p0 != cand_p1)
        cnt_p1 <= 16'd0;
      else if (cnt_p1 != STABLE_MAX)
        cnt_p1 <= cnt_p1 + 16'd1;
    end
  end

  assign settle = (seg_p0 == cand_p1) && (cnt_p1 == SETTLE_AT);

  state_t      state, state_n;
  logic [3:0]  code_r, code_n;
  logic        valid_r, valid_n;
  logic        ferr_r, ferr_n;
  logic [6:0]  held_r, held_n;
  logic [3:0]  idx_r, idx_n;
  logic        match_r, match_n;

  always_comb begin
    state_n = state;
    code_n  = code_r;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    held_n  = held_r;
    if (settle) begin
      case (state)
        IDLE: if (cand_p1 == 7'h00) state_n = GAP;
        GAP: begin
          if (cand_p1 != 7'h00) begin
            valid_n = 1'b1;
            code_n  = decode(cand_p1);
            held_n  = cand_p1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (cand_p1 == 7'h00)
            state_n = GAP;
          else if (cand_p1 != held_r)
            ferr_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Matcher works one cycle behind the framer, off the registered pulse.
  always_comb begin
    idx_n   = idx_r;
    match_n = 1'b0;
    if (valid_r) begin
      if (code_r == expected(idx_r)) begin
        if (idx_r == 4'd8) begin
          match_n = 1'b1;
          idx_n   = 4'd0;
        end else begin
          idx_n = idx_r + 4'd1;
        end
      end else if (code_r == 4'h1) begin
        idx_n = 4'd1;
      end else begin
        idx_n = 4'd0;
      end
    end
  end

  // Stage p2: framer and matcher registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      code_r  <= 4'h0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      idx_r   <= 4'd0;
      match_r <= 1'b0;
    end else begin
      state   <= state_n;
      code_r  <= code_n;
      valid_r <= valid_n;
      ferr_r  <= ferr_n;
      idx_r   <= idx_n;
      match_r <= match_n;
    end
  end

  // Only consulted in HOLD, which is always entered through a fresh capture.
  always_ff @(posedge clk) begin
    held_r <= held_n;
  end

  assign bus.char_code  = code_r;
  assign bus.char_valid = valid_r;
  assign bus.frame_err  = ferr_r;
  assign bus.msg_match  = match_r;
  assign bus.match_idx  = idx_r;

endmodule

// File: tb/tb_seg7_message_decoder.sv
// Scoreboard bench for seg7_message_decoder with STABLE_CYCLES = 4.
module tb_seg7_message_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_message_decoder_if bus();

  seg7_message_decoder #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int match_cnt = 0;
  int last_valid_cyc = -1;
  int last_match_cyc = -1;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;

  always @(posedge clk) cyc++;

  // Every char_valid pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    if (bus.char_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_char_valid: got code %h, no character expected", bus.char_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (bus.char_code !== exp_code) begin
          fails++;
          $display("FAIL char_code: got %h, expected %h", bus.char_code, exp_code);
        end
      end
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.msg_match === 1'b1) begin
      match_cnt++;
      last_match_cyc = cyc;
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    bus.seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic letter(input logic [6:0] p, input logic [3:0] code);
    exp_q.push_back(code);
    hold(p, 6);
    hold(7'h00, 6);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold(7'h00, 2);
    reset = 1'b0;
    hold(7'h00, 8);
  endtask

  task automatic send_message();
    letter(7'h76, 4'h1);
    letter(7'h79, 4'h2);
    letter(7'h38, 4'h3);
    letter(7'h38, 4'h3);
    letter(7'h3F, 4'h4);
    hold(7'h00, 6);
    letter(7'h77, 4'h5);
    letter(7'h6D, 4'h6);
    letter(7'h30, 4'h7);
    letter(7'h39, 4'h8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.seg_in = 7'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.char_code, bus.char_valid, bus.frame_err, bus.msg_match, bus.match_idx} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: code=%h valid=%b ferr=%b match=%b idx=%0d, expected all zero",
               bus.char_code, bus.char_valid, bus.frame_err, bus.msg_match, bus.match_idx);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic cv5, cv6;
    cv5 = 1'b0;
    cv6 = 1'b0;
    hold(7'h00, 8);
    exp_q.push_back(4'h1);
    bus.seg_in = 7'h76;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) cv5 = bus.char_valid;
      if (i == 6) cv6 = bus.char_valid;
    end
    tests++;
    if (cv5 !== 1'b0 || cv6 !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: valid after edge4=%b edge5=%b, expected 0 then 1", cv5, cv6);
    end
    hold(7'h76, 4);
    hold(7'h00, 6);
    tests++;
    if (valid_cnt !== 1 || ferr_cnt !== 0) begin
      fails++;
      $display("FAIL basic_counts: valid=%0d ferr=%0d, expected 1 and 0", valid_cnt, ferr_cnt);
    end
    tests++;
    if (bus.char_code !== 4'h1) begin
      fails++;
      $display("FAIL basic_code_hold: got %h, expected 1", bus.char_code);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    hold(7'h79, 3);
    hold(7'h00, 8);
    tests++;
    if (valid_cnt !== v0) begin
      fails++;
      $display("FAIL glitch_valid: got %0d pulses, expected 0", valid_cnt - v0);
    end
    tests++;
    if (bus.char_code !== 4'h1) begin
      fails++;
      $display("FAIL glitch_code: got %h, expected 1", bus.char_code);
    end
  endtask

  task automatic test_full_message();
    int v0, m0;
    do_reset();
    v0 = valid_cnt;
    m0 = match_cnt;
    send_message();
    tests++;
    if (valid_cnt - v0 !== 9) begin
      fails++;
      $display("FAIL msg_valid_count: got %0d, expected 9", valid_cnt - v0);
    end
    tests++;
    if (match_cnt - m0 !== 1) begin
      fails++;
      $display("FAIL msg_match_count: got %0d, expected 1", match_cnt - m0);
    end
    tests++;
    if (last_match_cyc !== last_valid_cyc + 1) begin
      fails++;
      $display("FAIL msg_match_timing: match at %0d, expected %0d", last_match_cyc, last_valid_cyc + 1);
    end
    tests++;
    if (bus.match_idx !== 4'd0) begin
      fails++;
      $display("FAIL msg_idx_end: got %0d, expected 0", bus.match_idx);
    end
  endtask

  task automatic test_no_separator();
    int v0, f0;
    do_reset();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(4'h1);
    hold(7'h76, 6);
    hold(7'h79, 6);
    hold(7'h00, 6);
    letter(7'h38, 4'h3);
    tests++;
    if (ferr_cnt - f0 !== 1) begin
      fails++;
      $display("FAIL nosep_frame_err: got %0d pulses, expected 1", ferr_cnt - f0);
    end
    tests++;
    if (valid_cnt - v0 !== 2) begin
      fails++;
      $display("FAIL nosep_valid: got %0d pulses, expected 2", valid_cnt - v0);
    end
    tests++;
    if (bus.match_idx !== 4'd0) begin
      fails++;
      $display("FAIL nosep_idx: got %0d, expected 0", bus.match_idx);
    end
  endtask

  task automatic test_unknown_restart();
    int m0;
    do_reset();
    m0 = match_cnt;
    letter(7'h76, 4'h1);
    letter(7'h79, 4'h2);
    letter(7'h38, 4'h3);
    tests++;
    if (bus.match_idx !== 4'd3) begin
      fails++;
      $display("FAIL unk_idx_before: got %0d, expected 3", bus.match_idx);
    end
    letter(7'h7F, 4'hF);
    tests++;
    if (bus.match_idx !== 4'd0 || bus.char_code !== 4'hF) begin
      fails++;
      $display("FAIL unk_after: idx=%0d code=%h, expected 0 and F", bus.match_idx, bus.char_code);
    end
    send_message();
    tests++;
    if (match_cnt - m0 !== 1 || bus.match_idx !== 4'd0) begin
      fails++;
      $display("FAIL unk_restart_match: matches=%0d idx=%0d, expected 1 and 0", match_cnt - m0, bus.match_idx);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    letter(7'h76, 4'h1);
    letter(7'h79, 4'h2);
    letter(7'h38, 4'h3);
    tests++;
    if (bus.match_idx !== 4'd3) begin
      fails++;
      $display("FAIL mid_idx_before: got %0d, expected 3", bus.match_idx);
    end
    bus.seg_in = 7'h38;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.char_code, bus.char_valid, bus.frame_err, bus.msg_match, bus.match_idx} !== 11'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: code=%h valid=%b ferr=%b match=%b idx=%0d, expected all zero",
               bus.char_code, bus.char_valid, bus.frame_err, bus.msg_match, bus.match_idx);
    end
    reset = 1'b0;
    v0 = valid_cnt;
    hold(7'h38, 10);
    tests++;
    if (valid_cnt !== v0) begin
      fails++;
      $display("FAIL mid_idle_ignore: got %0d pulses, expected 0", valid_cnt - v0);
    end
    hold(7'h00, 8);
    letter(7'h76, 4'h1);
    tests++;
    if (valid_cnt - v0 !== 1 || bus.match_idx !== 4'd1) begin
      fails++;
      $display("FAIL mid_recover: pulses=%0d idx=%0d, expected 1 and 1", valid_cnt - v0, bus.match_idx);
    end
  endtask

  initial begin
    bus.seg_in = 7'h00;
    test_reset();
    test_basic();
    test_glitch();
    test_full_message();
    test_no_separator();
    test_unknown_restart();
    test_reset_mid();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d characters never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
